// File: rtl/beep_pkg.sv
// Shared constants, counter width and FSM encoding for the beep tone detector.
package beep_pkg;
  localparam int CNT_W   = 21;
  localparam int MATCH_W = 3;

  localparam logic [CNT_W-1:0] CNT_SAT = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  localparam logic [CNT_W-1:0] PERIOD_MIN_DEF = 21'd950_000;
  localparam logic [CNT_W-1:0] PERIOD_MAX_DEF = 21'd1_050_000;
  localparam logic [CNT_W-1:0] HIGH_MIN_DEF   = 21'd450_000;
  localparam logic [CNT_W-1:0] HIGH_MAX_DEF   = 21'd550_000;
  localparam int unsigned      MATCH_NUM_DEF  = 3;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    LOCKING,
    LOCKED
  } state_e;

  function automatic logic in_range(input logic [CNT_W-1:0] v,
                                    input logic [CNT_W-1:0] lo,
                                    input logic [CNT_W-1:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction
endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer plus registered rising-edge detector; level_o is
// delayed to stay aligned with rise_o so the edge cycle reads as high.
module sync_edge (
  input  logic clk_i,
  input  logic rst_i,
  input  logic async_i,
  output logic level_o,
  output logic rise_o
);
  logic meta_q, sync_q, prev_q, rise_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
      rise_q <= sync_q & ~prev_q;
    end
  end

  assign level_o = prev_q;
  assign rise_o  = rise_q;
endmodule

// File: rtl/beep_detect.sv
// Beep tone detector: measures period and high time of a synchronized square
// wave and asserts tone_valid after MATCH_NUM consecutive conforming periods.
module beep_detect
  import beep_pkg::*;
#(
  parameter logic [CNT_W-1:0] PERIOD_MIN = PERIOD_MIN_DEF,
  parameter logic [CNT_W-1:0] PERIOD_MAX = PERIOD_MAX_DEF,
  parameter logic [CNT_W-1:0] HIGH_MIN   = HIGH_MIN_DEF,
  parameter logic [CNT_W-1:0] HIGH_MAX   = HIGH_MAX_DEF,
  parameter int unsigned      MATCH_NUM  = MATCH_NUM_DEF
) (
  input  logic             ext_clk_25m,
  input  logic             ext_rst,
  input  logic             beep_in,
  output logic             tone_valid,
  output logic             meas_stb,
  output logic [CNT_W-1:0] period_out,
  output logic [CNT_W-1:0] high_out
);
  localparam logic [MATCH_W:0] MATCH_LIM = MATCH_NUM[MATCH_W:0];

  logic level, rise;

  sync_edge u_sync (
    .clk_i   (ext_clk_25m),
    .rst_i   (ext_rst),
    .async_i (beep_in),
    .level_o (level),
    .rise_o  (rise)
  );

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   hcnt_q, hcnt_d;
  logic [MATCH_W-1:0] match_q, match_d;
  logic [CNT_W-1:0]   period_q, period_d;
  logic [CNT_W-1:0]   high_q, high_d;
  logic               stb_q, stb_d;
  logic               tone_q, tone_d;

  logic [CNT_W-1:0]   meas_period;
  logic               meas_ok;
  logic [MATCH_W:0]   match_inc;

  // The edge cycle closes the running period, so it is counted in the result.
  assign meas_period = cnt_q + CNT_ONE;
  assign meas_ok     = in_range(meas_period, PERIOD_MIN, PERIOD_MAX) &&
                       in_range(hcnt_q, HIGH_MIN, HIGH_MAX);
  assign match_inc   = {1'b0, match_q} + {{MATCH_W{1'b0}}, 1'b1};

  always_ff @(posedge ext_clk_25m or posedge ext_rst) begin
    if (ext_rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      hcnt_q   <= '0;
      match_q  <= '0;
      period_q <= '0;
      high_q   <= '0;
      stb_q    <= 1'b0;
      tone_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hcnt_q   <= hcnt_d;
      match_q  <= match_d;
      period_q <= period_d;
      high_q   <= high_d;
      stb_q    <= stb_d;
      tone_q   <= tone_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    match_d  = match_q;
    period_d = period_q;
    high_d   = high_q;
    stb_d    = 1'b0;
    cnt_d    = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CNT_ONE;
    hcnt_d   = (level && (hcnt_q != CNT_SAT)) ? hcnt_q + CNT_ONE : hcnt_q;

    if (rise) begin
      cnt_d  = '0;
      hcnt_d = CNT_ONE;
    end

    // An edge always wins over a timeout landing in the same cycle.
    if (state_q == IDLE) begin
      if (rise) state_d = ARMED;
    end else if (rise) begin
      stb_d    = 1'b1;
      period_d = meas_period;
      high_d   = hcnt_q;
      if (meas_ok) begin
        if (match_inc >= MATCH_LIM) begin
          state_d = LOCKED;
          match_d = MATCH_LIM[MATCH_W-1:0];
        end else begin
          state_d = LOCKING;
          match_d = match_inc[MATCH_W-1:0];
        end
      end else begin
        state_d = ARMED;
        match_d = '0;
      end
    end else if (cnt_q == PERIOD_MAX) begin
      state_d = IDLE;
      match_d = '0;
    end

    tone_d = (state_d == LOCKED);
  end

  assign tone_valid = tone_q;
  assign meas_stb   = stb_q;
  assign period_out = period_q;
  assign high_out   = high_q;
endmodule

// File: tb/tb_beep_detect.sv
// Self-checking bench for beep_detect with shortened thresholds and a
// period-level reference model delayed by the three-cycle input latency.
module tb_beep_detect;
  localparam int PMIN = 95;
  localparam int PMAX = 105;
  localparam int HMIN = 45;
  localparam int HMAX = 55;
  localparam int MNUM = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        beepIn = 1'b0;
  logic        toneValid, measStb;
  logic [20:0] periodOut, highOut;

  beep_detect #(
    .PERIOD_MIN (21'(PMIN)),
    .PERIOD_MAX (21'(PMAX)),
    .HIGH_MIN   (21'(HMIN)),
    .HIGH_MAX   (21'(HMAX)),
    .MATCH_NUM  (MNUM)
  ) dut (
    .ext_clk_25m (clk),
    .ext_rst     (rst),
    .beep_in     (beepIn),
    .tone_valid  (toneValid),
    .meas_stb    (measStb),
    .period_out  (periodOut),
    .high_out    (highOut)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        tv;
    logic        stb;
    logic [20:0] per;
    logic [20:0] hi;
  } exp_t;

  int   errors = 0;
  int   checks = 0;
  exp_t pipe[$];

  // Reference model: works on input-sample indices and whole periods.
  int   n, mLast, mHighs, mMatch;
  bit   prevB, mActive, mLocked;
  exp_t mOut;

  task automatic modelReset();
    n = 0; mLast = 0; mHighs = 0; mMatch = 0;
    prevB = 1'b0; mActive = 1'b0; mLocked = 1'b0;
    mOut = '0;
    pipe.delete();
  endtask

  task automatic modelStep(input bit b);
    bit rise = b && !prevB;
    int per;
    mOut.stb = 1'b0;
    if (rise) begin
      if (mActive) begin
        per = n - mLast;
        mOut.stb = 1'b1;
        mOut.per = 21'(per);
        mOut.hi  = 21'(mHighs);
        if (per >= PMIN && per <= PMAX && mHighs >= HMIN && mHighs <= HMAX) begin
          mMatch  = (mMatch + 1 > MNUM) ? MNUM : mMatch + 1;
          mLocked = (mMatch == MNUM);
        end else begin
          mMatch  = 0;
          mLocked = 1'b0;
        end
      end
      mActive = 1'b1;
      mLast   = n;
      mHighs  = 0;
    end else if (mActive && (n - mLast) == PMAX + 1) begin
      mActive = 1'b0;
      mMatch  = 0;
      mLocked = 1'b0;
    end
    if (b) mHighs++;
    mOut.tv = mLocked;
    prevB = b;
    n++;
  endtask

  function automatic exp_t obsNow();
    return {toneValid, measStb, periodOut, highOut};
  endfunction

  // Drives one input sample and returns the model output due on this cycle.
  task automatic runCycle(input bit b, output exp_t e);
    beepIn = b;
    @(posedge clk);
    modelStep(b);
    pipe.push_back(mOut);
    @(negedge clk);
    if (pipe.size() > 3) e = pipe.pop_front();
    else e = '0;
  endtask

  task automatic test_reset();
    beepIn = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (obsNow() !== exp_t'(0)) begin
      errors++;
      $display("[TB] FAIL reset_state got=%h want=0", obsNow());
    end
    rst = 1'b0;
    modelReset();
  endtask

  task automatic test_lock();
    exp_t e;
    for (int i = 0; i < 5; i++) begin
      for (int c = 0; c < 100; c++) begin
        runCycle(c < 50, e);
        checks++;
        if (obsNow() !== e) begin
          errors++;
          $display("[TB] FAIL lock_track i=%0d c=%0d got=%h want=%h", i, c, obsNow(), e);
        end
        if (i == 3 && c == 2) begin
          checks++;
          if (toneValid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL lock_early got=%b want=0", toneValid);
          end
        end
        if (i == 3 && c == 3) begin
          checks++;
          if ({toneValid, measStb, periodOut, highOut} !== {1'b1, 1'b1, 21'd100, 21'd50}) begin
            errors++;
            $display("[TB] FAIL lock_4th tv=%b stb=%b per=%0d hi=%0d want 1 1 100 50",
                     toneValid, measStb, periodOut, highOut);
          end
        end
      end
    end
  endtask

  task automatic test_bad_duty();
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      for (int c = 0; c < 100; c++) begin
        runCycle(c < ((i == 0) ? 30 : 50), e);
        checks++;
        if (obsNow() !== e) begin
          errors++;
          $display("[TB] FAIL duty_track i=%0d c=%0d got=%h want=%h", i, c, obsNow(), e);
        end
        if (i == 1 && c == 2) begin
          checks++;
          if (toneValid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL duty_prelock got=%b want=1", toneValid);
          end
        end
        if (i == 1 && c == 3) begin
          checks++;
          if ({toneValid, measStb, periodOut, highOut} !== {1'b0, 1'b1, 21'd100, 21'd30}) begin
            errors++;
            $display("[TB] FAIL duty_drop tv=%b stb=%b per=%0d hi=%0d want 0 1 100 30",
                     toneValid, measStb, periodOut, highOut);
          end
        end
      end
    end
  endtask

  task automatic test_timeout();
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      for (int c = 0; c < ((i == 3) ? 130 : 100); c++) begin
        runCycle(c < 50, e);
        checks++;
        if (obsNow() !== e) begin
          errors++;
          $display("[TB] FAIL timeout_track i=%0d c=%0d got=%h want=%h", i, c, obsNow(), e);
        end
        if (i == 3 && c == 108) begin
          checks++;
          if (toneValid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL timeout_early got=%b want=1", toneValid);
          end
        end
        if (i == 3 && (c == 109 || c == 129)) begin
          checks++;
          if ({toneValid, periodOut, highOut} !== {1'b0, 21'd100, 21'd50}) begin
            errors++;
            $display("[TB] FAIL timeout_drop c=%0d tv=%b per=%0d hi=%0d want 0 100 50",
                     c, toneValid, periodOut, highOut);
          end
        end
      end
    end
  endtask

  task automatic test_bounds();
    int   per[9]  = '{95, 105, 94, 95, 105, 95, 106, 95, 100};
    bit   tvAt[9] = '{0, 0, 0, 0, 0, 0, 1, 0, 0};
    exp_t e;
    for (int i = 0; i < 9; i++) begin
      for (int c = 0; c < per[i]; c++) begin
        runCycle(c < per[i] / 2, e);
        checks++;
        if (obsNow() !== e) begin
          errors++;
          $display("[TB] FAIL bounds_track i=%0d c=%0d got=%h want=%h", i, c, obsNow(), e);
        end
        if (i >= 1 && c == 3) begin
          checks++;
          if ({toneValid, measStb, periodOut, highOut} !==
              {tvAt[i], 1'b1, 21'(per[i-1]), 21'(per[i-1] / 2)}) begin
            errors++;
            $display("[TB] FAIL bounds_meas i=%0d tv=%b stb=%b per=%0d hi=%0d want %b 1 %0d %0d",
                     i, toneValid, measStb, periodOut, highOut, tvAt[i], per[i-1], per[i-1] / 2);
          end
        end
      end
    end
  endtask

  task automatic test_reset_midlock();
    exp_t e;
    for (int i = 0; i < 5; i++) begin
      for (int c = 0; c < 100; c++) begin
        runCycle(c < 50, e);
        checks++;
        if (obsNow() !== e) begin
          errors++;
          $display("[TB] FAIL prereset_track i=%0d c=%0d got=%h want=%h", i, c, obsNow(), e);
        end
      end
    end
    checks++;
    if (toneValid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL prereset_lock got=%b want=1", toneValid);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (obsNow() !== exp_t'(0)) begin
      errors++;
      $display("[TB] FAIL reset_async got=%h want=0", obsNow());
    end
    @(negedge clk);
    rst = 1'b0;
    modelReset();
    for (int i = 0; i < 5; i++) begin
      for (int c = 0; c < 100; c++) begin
        runCycle(c < 50, e);
        checks++;
        if (obsNow() !== e) begin
          errors++;
          $display("[TB] FAIL relock_track i=%0d c=%0d got=%h want=%h", i, c, obsNow(), e);
        end
        if (i == 3 && (c == 2 || c == 3)) begin
          checks++;
          if (toneValid !== (c == 3)) begin
            errors++;
            $display("[TB] FAIL relock_4th c=%0d got=%b want=%b", c, toneValid, c == 3);
          end
        end
      end
    end
  endtask

  task automatic test_random();
    exp_t e;
    int   per, hi;
    for (int i = 0; i < 40; i++) begin
      per = ($urandom_range(0, 7) == 0) ? $urandom_range(104, 140) : $urandom_range(90, 110);
      hi  = $urandom_range(40, 60);
      for (int c = 0; c < per; c++) begin
        runCycle(c < hi, e);
        checks++;
        if (obsNow() !== e) begin
          errors++;
          $display("[TB] FAIL random_track i=%0d per=%0d hi=%0d c=%0d got=%h want=%h",
                   i, per, hi, c, obsNow(), e);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_bad_duty();
    test_timeout();
    test_bounds();
    test_reset_midlock();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
